hps_result_capture: RTL
=======================

Name: hps_result_capture

Overview:
- Fabric-to-HPS direction of the lightweight-bridge PIO path: the ANN fabric pushes result words, and HPS software reads them through a 4-word Avalon-MM slave.
- Buffers up to DEPTH results in a FIFO.
- Exposes fill level, sticky overflow and an interrupt, so the HPS can poll or take an interrupt instead of sampling a live port.

Parameters:
- DATA_W, 20, result word width (≤ 32); zero-extended onto readdata.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, derived localparam; fill-count width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe (qualified by chipselect).
- write_n  in  1  Avalon write strobe, active-low (qualified by chipselect).
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; read latency 0 (combinational from address and registers).
- in_data  in  DATA_W  fabric result word.
- in_valid  in  1  fabric result strobe; one word per cycle high.
- in_ready  out  1  equals !full; depends on registered state only.
- irq  out  1  interrupt to HPS, level.

Behaviour:
- Reset (reset_n low at a clk edge):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - overflow = 0, irq_en = 0.
  - Result: irq = 0, in_ready = 1, readdata reflects the reset registers.
- Reset mid-operation discards all FIFO contents. Storage RAM contents need no reset.
- Register map (word addresses):
  - 0 DATA (RO): head entry zero-extended; returns 0 when empty. chipselect & read & !empty pops at the clock edge. Reading when empty has no effect. Writes are ignored.
  - 1 STATUS: [CNT_W-1:0] = count; bit16 = overflow (sticky); bit17 = empty; bit18 = full; other bits 0. Writing 1 to bit16 clears overflow; other bits are ignored.
  - 2 IRQ_EN (RW): bit0 = irq_en; other bits read 0.
  - 3 CONTROL: write with bit0 = 1 flushes the FIFO (pointers and count to 0). Reads 0.
- Write strobe = chipselect & !write_n. Read and write in the same cycle are legal and act independently.
- Push = in_valid & !full. in_valid & full drops the word and sets overflow in that cycle. The source is allowed to ignore in_ready.
- Full is evaluated on the registered count. A push while full is dropped even if a pop happens in the same cycle, so there is no combinational path from Avalon to in_ready.
- Simultaneous push and pop (0 < count < DEPTH): both occur, count is unchanged, and the popped word is the old head.
- Push into an empty FIFO: the word is visible at DATA on the next cycle (1-cycle latency); irq rises on the same cycle.
- Flush in the same cycle as a push and/or pop: flush wins, count = 0, the pushed word is lost. Overflow is not set by a flush and is not cleared by it.
- Overflow set and overflow clear in the same cycle: set wins.
- Pointers wrap modulo DEPTH. count saturates by construction: a push is never accepted at DEPTH, and a pop is never performed at 0.
- irq = irq_en & (count != 0), combinational from registers.

Decomposition:
- Package hps_capture_pkg holds:
  - register address constants: ADDR_DATA = 0, ADDR_STATUS = 1, ADDR_IRQ_EN = 2, ADDR_CONTROL = 3;
  - STATUS bit positions: OVF_BIT = 16, EMPTY_BIT = 17, FULL_BIT = 18;
  - the CTRL_FLUSH_BIT = 0 constant.
- One sub-module, hps_sync_fifo:
  - parameters DATA_W and DEPTH;
  - ports push, pop, flush, wdata, rdata (show-ahead head), count, empty, full.
- The top level holds the Avalon decode, overflow, irq_en and the readdata mux.

Test Plan:
- After reset: read STATUS -> 0x00020000 (empty, count 0); in_ready = 1; irq = 0.
- Push 0xABCDE and 0x12345 on consecutive cycles, then read DATA twice -> 0x000ABCDE, then 0x00012345. STATUS count goes 2 -> 1 -> 0.
- Overflow at DEPTH = 4:
  - Push 5 words 1..5 back-to-back -> in_ready goes 0 after the 4th; STATUS = 0x00050004 (full, overflow, count 4).
  - Reads return 1, 2, 3, 4; word 5 is lost.
  - Write STATUS 0x10000 -> overflow clears.
- Simultaneous push and pop at count 2 -> count stays 2 and the old head is returned. With the FIFO full, push plus pop -> the push is dropped, overflow = 1, count = 3.
- Write IRQ_EN = 1 with the FIFO empty -> irq = 0. Push one word -> irq = 1 on the next cycle. Read DATA -> irq = 0 on the following cycle.
- Flush and reset:
  - With count 3, write CONTROL = 1 in the same cycle as in_valid -> count = 0 and overflow unchanged.
  - Assert reset_n = 0 for one edge with count 2 and irq_en = 1 -> STATUS = 0x00020000, IRQ_EN = 0, irq = 0.

Source files
------------

// File: rtl/hps_result_capture_pkg.sv
// Register map constants for the fabric-to-HPS result capture block.
package hps_capture_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_IRQ_EN  = 2'd2;
   localparam logic [1:0] ADDR_CONTROL = 2'd3;

   localparam int OVF_BIT        = 16;
   localparam int EMPTY_BIT      = 17;
   localparam int FULL_BIT       = 18;
   localparam int CTRL_FLUSH_BIT = 0;
endpackage

// File: rtl/hps_result_capture_if.sv
// Avalon-MM slave bus seen by the HPS lightweight bridge.
interface hps_result_capture_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, read, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/hps_sync_fifo.sv
// Show-ahead synchronous FIFO; flush overrides push and pop.
module hps_sync_fifo #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == CNT_W'(DEPTH));
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign rdata  = r_mem[r_rd_ptr];
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Storage is not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata;
   end
endmodule

// File: rtl/hps_result_capture.sv
// Result FIFO with Avalon-MM status/data registers and level interrupt.
module hps_result_capture
   import hps_capture_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   hps_result_capture_if.slave avs,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              irq
);
   logic              r_overflow;
   logic              r_irq_en;
   logic              w_wr;
   logic              w_rd;
   logic              w_pop;
   logic              w_push;
   logic              w_flush;
   logic              w_ovf_set;
   logic              w_ovf_clr;
   logic [DATA_W-1:0] w_head;
   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic              w_full;
   logic              w_unused_wd;

   assign w_wr = avs.chipselect & ~avs.write_n;
   assign w_rd = avs.chipselect & avs.read;

   assign w_pop   = w_rd & (avs.address == ADDR_DATA) & ~w_empty;
   assign w_push  = in_valid & ~w_full;
   assign w_flush = w_wr & (avs.address == ADDR_CONTROL)
                  & avs.writedata[CTRL_FLUSH_BIT];

   assign w_ovf_set = in_valid & w_full;
   assign w_ovf_clr = w_wr & (avs.address == ADDR_STATUS)
                    & avs.writedata[OVF_BIT];

   assign w_unused_wd = ^{avs.writedata[31:17], avs.writedata[15:1]};

   hps_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (w_flush),
      .wdata   (in_data),
      .rdata   (w_head),
      .count   (w_count),
      .empty   (w_empty),
      .full    (w_full)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
         r_irq_en   <= 1'b0;
      end else begin
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
         if (w_wr && avs.address == ADDR_IRQ_EN)
            r_irq_en <= avs.writedata[0];
      end
   end

   assign in_ready = ~w_full;
   assign irq      = r_irq_en & ~w_empty;

   always_comb begin
      avs.readdata = '0;
      unique case (avs.address)
         ADDR_DATA: begin
            if (!w_empty) avs.readdata[DATA_W-1:0] = w_head;
         end
         ADDR_STATUS: begin
            avs.readdata[CNT_W-1:0] = w_count;
            avs.readdata[OVF_BIT]   = r_overflow;
            avs.readdata[EMPTY_BIT] = w_empty;
            avs.readdata[FULL_BIT]  = w_full;
         end
         ADDR_IRQ_EN:  avs.readdata[0] = r_irq_en;
         ADDR_CONTROL: avs.readdata = '0;
         default:      avs.readdata = '0;
      endcase
   end
endmodule
